// File: rtl/rtc_pkg.sv
// Shared constants, types and helpers for the multi-alarm real-time clock.
// Time fields are hr[4:0], min[5:0], sec[5:0]; alarm timers count seconds.
package rtc_pkg;

  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned TMR_W = 12;

  localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(23);
  localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic             en;
  } alarm_t;

  // True when hr:min is a legal 24 h wall-clock time.
  function automatic logic valid_hm(input logic [HR_W-1:0] hr, input logic [MIN_W-1:0] min);
    return (hr <= HR_MAX) && (min <= MIN_MAX);
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Seconds prescaler: emits a registered one-cycle tick every CLK_HZ cycles.
// clr restarts the count and drops any pending tick.
module rtc_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/rtc_multi_alarm.sv
// 24 h real-time clock with N alarm channels, snooze, dismiss and ring timeout.
// Everything runs on clk; the seconds tick is a one-cycle enable.
module rtc_multi_alarm
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 1,
  localparam int unsigned IDX_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_time_i,
  input  logic [HR_W-1:0]  set_hr_i,
  input  logic [MIN_W-1:0] set_min_i,
  input  logic             alarm_wr_i,
  input  logic [IDX_W-1:0] alarm_idx_i,
  input  logic [HR_W-1:0]  alarm_hr_i,
  input  logic [MIN_W-1:0] alarm_min_i,
  input  logic             alarm_en_i,
  input  logic             snooze_i,
  input  logic             dismiss_i,
  output logic [HR_W-1:0]  hr_o,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic             sec_tick_o,
  output logic             buzzer_o,
  output logic [IDX_W-1:0] ring_idx_o,
  output logic             snoozed_o
);

  localparam logic [TMR_W-1:0] RING_TICKS   = TMR_W'(RING_MIN * 60);
  localparam logic [TMR_W-1:0] SNOOZE_TICKS = TMR_W'(SNOOZE_MIN * 60);

  logic             tick;
  logic             set_ok;
  logic             wr_ok;
  logic             rollover;
  logic             match_hit;
  logic             match;
  logic             en_lost;
  logic [IDX_W-1:0] match_idx;

  logic [HR_W-1:0]  hr_q, hr_d, nxt_hr;
  logic [MIN_W-1:0] min_q, min_d, nxt_min;
  logic [SEC_W-1:0] sec_q, sec_d;

  alarm_t           alarms_q [N_ALARMS];
  alarm_t           alarms_d [N_ALARMS];

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] ring_idx_q, ring_idx_d;

  rtc_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (set_ok),
    .tick (tick)
  );

  assign set_ok   = set_time_i && valid_hm(set_hr_i, set_min_i);
  assign wr_ok    = alarm_wr_i && valid_hm(alarm_hr_i, alarm_min_i)
                    && (32'(alarm_idx_i) < N_ALARMS);
  assign rollover = tick && !set_ok && (sec_q >= SEC_MAX);
  assign match    = rollover && match_hit;
  assign en_lost  = wr_ok && (alarm_idx_i == ring_idx_q) && !alarm_en_i;

  // Wall-clock advance; a valid set_time overrides a coincident tick.
  always_comb begin
    nxt_min = (min_q >= MIN_MAX) ? '0 : min_q + MIN_W'(1);
    nxt_hr  = hr_q;
    if (min_q >= MIN_MAX) begin
      nxt_hr = (hr_q >= HR_MAX) ? '0 : hr_q + HR_W'(1);
    end
    hr_d  = hr_q;
    min_d = min_q;
    sec_d = sec_q;
    if (set_ok) begin
      hr_d  = set_hr_i;
      min_d = set_min_i;
      sec_d = '0;
    end else if (tick) begin
      if (sec_q >= SEC_MAX) begin
        sec_d = '0;
        min_d = nxt_min;
        hr_d  = nxt_hr;
      end else begin
        sec_d = sec_q + SEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr_q  <= '0;
      min_q <= '0;
      sec_q <= '0;
    end else begin
      hr_q  <= hr_d;
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  // Alarm table write port.
  always_comb begin
    for (int i = 0; i < int'(N_ALARMS); i++) begin
      alarms_d[i] = alarms_q[i];
    end
    if (wr_ok) begin
      alarms_d[alarm_idx_i].hr  = alarm_hr_i;
      alarms_d[alarm_idx_i].min = alarm_min_i;
      alarms_d[alarm_idx_i].en  = alarm_en_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ALARMS); i++) begin
        alarms_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_ALARMS); i++) begin
        alarms_q[i] <= alarms_d[i];
      end
    end
  end

  // Compare against the upcoming hr:min; scanning downward leaves the lowest index.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
      if (alarms_q[i].en && (alarms_q[i].hr == nxt_hr) && (alarms_q[i].min == nxt_min)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // FSM state register, with its timer and latched channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ring_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ring_idx_q <= ring_idx_d;
    end
  end

  // FSM next state; dismiss outranks snooze, matches outside IDLE are dropped.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ring_idx_d = ring_idx_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (match) begin
          state_d    = RINGING;
          timer_d    = RING_TICKS;
          ring_idx_d = match_idx;
        end
      end
      RINGING: begin
        if (dismiss_i || en_lost) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (snooze_i) begin
          state_d = SNOOZED;
          timer_d = SNOOZE_TICKS;
        end else if (tick) begin
          if (timer_q <= TMR_W'(1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      SNOOZED: begin
        if (dismiss_i || en_lost) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (tick) begin
          if (timer_q <= TMR_W'(1)) begin
            state_d = RINGING;
            timer_d = RING_TICKS;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    buzzer_o  = 1'b0;
    snoozed_o = 1'b0;
    case (state_q)
      RINGING: buzzer_o  = 1'b1;
      SNOOZED: snoozed_o = 1'b1;
      default: ;
    endcase
  end

  assign hr_o       = hr_q;
  assign min_o      = min_q;
  assign sec_o      = sec_q;
  assign sec_tick_o = tick;
  assign ring_idx_o = ring_idx_q;

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed bench for rtc_multi_alarm with a 4-cycle second and short alarm timers.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rtc_multi_alarm;

  localparam int unsigned CLK_HZ     = 4;
  localparam int unsigned N_ALARMS   = 4;
  localparam int unsigned SNOOZE_MIN = 1;
  localparam int unsigned RING_MIN   = 2;
  localparam int          TICK_LIM   = 2 * CLK_HZ + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_time_i;
  logic [4:0] set_hr_i;
  logic [5:0] set_min_i;
  logic       alarm_wr_i;
  logic [1:0] alarm_idx_i;
  logic [4:0] alarm_hr_i;
  logic [5:0] alarm_min_i;
  logic       alarm_en_i;
  logic       snooze_i;
  logic       dismiss_i;
  logic [4:0] hr_o;
  logic [5:0] min_o;
  logic [5:0] sec_o;
  logic       sec_tick_o;
  logic       buzzer_o;
  logic [1:0] ring_idx_o;
  logic       snoozed_o;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_multi_alarm #(
    .CLK_HZ     (CLK_HZ),
    .N_ALARMS   (N_ALARMS),
    .SNOOZE_MIN (SNOOZE_MIN),
    .RING_MIN   (RING_MIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .set_time_i  (set_time_i),
    .set_hr_i    (set_hr_i),
    .set_min_i   (set_min_i),
    .alarm_wr_i  (alarm_wr_i),
    .alarm_idx_i (alarm_idx_i),
    .alarm_hr_i  (alarm_hr_i),
    .alarm_min_i (alarm_min_i),
    .alarm_en_i  (alarm_en_i),
    .snooze_i    (snooze_i),
    .dismiss_i   (dismiss_i),
    .hr_o        (hr_o),
    .min_o       (min_o),
    .sec_o       (sec_o),
    .sec_tick_o  (sec_tick_o),
    .buzzer_o    (buzzer_o),
    .ring_idx_o  (ring_idx_o),
    .snoozed_o   (snoozed_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hr"},  32'(hr_o),  32'(h));
    check({tag, ".min"}, 32'(min_o), 32'(m));
    check({tag, ".sec"}, 32'(sec_o), 32'(s));
  endtask

  // Consume n seconds; returns on the falling edge just after the n-th time update.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int budget;
      budget = 0;
      while (!sec_tick_o && budget < TICK_LIM) begin
        @(negedge clk);
        budget++;
      end
      if (!sec_tick_o) begin
        n_checks++;
        n_fail++;
        $error("FAIL tick_timeout: observed no sec_tick after %0d cycles, expected one", budget);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_set(input int h, input int m);
    set_hr_i   = 5'(h);
    set_min_i  = 6'(m);
    set_time_i = 1'b1;
    @(negedge clk);
    set_time_i = 1'b0;
  endtask

  task automatic do_wr(input int idx, input int h, input int m, input logic en);
    alarm_idx_i = 2'(idx);
    alarm_hr_i  = 5'(h);
    alarm_min_i = 6'(m);
    alarm_en_i  = en;
    alarm_wr_i  = 1'b1;
    @(negedge clk);
    alarm_wr_i  = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic d);
    snooze_i  = s;
    dismiss_i = d;
    @(negedge clk);
    snooze_i  = 1'b0;
    dismiss_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    set_time_i  = 1'b0;
    set_hr_i    = '0;
    set_min_i   = '0;
    alarm_wr_i  = 1'b0;
    alarm_idx_i = '0;
    alarm_hr_i  = '0;
    alarm_min_i = '0;
    alarm_en_i  = 1'b0;
    snooze_i    = 1'b0;
    dismiss_i   = 1'b0;

    // Reset state and first-tick latency
    repeat (2) @(negedge clk);
    check_time("reset", 0, 0, 0);
    check("reset.buzzer", 32'(buzzer_o), 0);
    check("reset.snoozed", 32'(snoozed_o), 0);
    check("reset.ring_idx", 32'(ring_idx_o), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("tick.before4", 32'(sec_tick_o), 0);
    @(negedge clk);
    check("tick.at4", 32'(sec_tick_o), 1);
    @(negedge clk);
    check("tick.sec1", 32'(sec_o), 1);
    check("tick.drop", 32'(sec_tick_o), 0);

    // Midnight wrap
    do_set(23, 59);
    check_time("set2359", 23, 59, 0);
    wait_ticks(59);
    check_time("t235959", 23, 59, 59);
    wait_ticks(1);
    check_time("midnight", 0, 0, 0);
    check("midnight.buzzer", 32'(buzzer_o), 0);

    // Single alarm, dismiss, no re-trigger within the minute
    do_wr(2, 7, 30, 1'b1);
    do_set(7, 29);
    wait_ticks(59);
    check_time("t072959", 7, 29, 59);
    check("pre0730.buzzer", 32'(buzzer_o), 0);
    wait_ticks(1);
    check_time("t073000", 7, 30, 0);
    check("ring0730.buzzer", 32'(buzzer_o), 1);
    check("ring0730.idx", 32'(ring_idx_o), 2);
    wait_ticks(10);
    check("t073010.sec", 32'(sec_o), 10);
    check("t073010.buzzer", 32'(buzzer_o), 1);
    pulse(1'b0, 1'b1);
    check("dismiss.buzzer", 32'(buzzer_o), 0);
    wait_ticks(49);
    check("t073059.sec", 32'(sec_o), 59);
    check("t073059.buzzer", 32'(buzzer_o), 0);
    wait_ticks(1);
    check("t073100.min", 32'(min_o), 31);
    check("t073100.buzzer", 32'(buzzer_o), 0);

    // Two channels on the same minute, auto-dismiss after RING_MIN minutes
    do_wr(1, 8, 0, 1'b1);
    do_wr(3, 8, 0, 1'b1);
    do_set(7, 59);
    wait_ticks(60);
    check_time("t080000", 8, 0, 0);
    check("ring0800.buzzer", 32'(buzzer_o), 1);
    check("ring0800.idx", 32'(ring_idx_o), 1);
    wait_ticks(119);
    check_time("t080159", 8, 1, 59);
    check("t080159.buzzer", 32'(buzzer_o), 1);
    wait_ticks(1);
    check_time("t080200", 8, 2, 0);
    check("timeout.buzzer", 32'(buzzer_o), 0);

    // Snooze: ignored in IDLE, then ring/snooze/re-ring, then snooze+dismiss
    pulse(1'b1, 1'b0);
    check("idle_snooze.snoozed", 32'(snoozed_o), 0);
    do_wr(0, 9, 0, 1'b1);
    do_set(8, 59);
    wait_ticks(60);
    check("ring0900.buzzer", 32'(buzzer_o), 1);
    check("ring0900.idx", 32'(ring_idx_o), 0);
    pulse(1'b1, 1'b0);
    check("snooze.buzzer", 32'(buzzer_o), 0);
    check("snooze.snoozed", 32'(snoozed_o), 1);
    wait_ticks(59);
    check("snooze59.snoozed", 32'(snoozed_o), 1);
    check("snooze59.buzzer", 32'(buzzer_o), 0);
    wait_ticks(1);
    check("rering.buzzer", 32'(buzzer_o), 1);
    check("rering.snoozed", 32'(snoozed_o), 0);
    check("rering.idx", 32'(ring_idx_o), 0);
    check("rering.min", 32'(min_o), 1);
    pulse(1'b1, 1'b1);
    check("both.buzzer", 32'(buzzer_o), 0);
    check("both.snoozed", 32'(snoozed_o), 0);

    // Illegal writes ignored while ringing; disabling the ringing channel stops it
    do_wr(3, 10, 0, 1'b1);
    do_set(9, 59);
    wait_ticks(60);
    check("ring1000.buzzer", 32'(buzzer_o), 1);
    check("ring1000.idx", 32'(ring_idx_o), 3);
    do_wr(3, 24, 0, 1'b0);
    check("bad_hr_wr.buzzer", 32'(buzzer_o), 1);
    do_wr(3, 10, 60, 1'b0);
    check("bad_min_wr.buzzer", 32'(buzzer_o), 1);
    do_set(25, 0);
    check("bad_set.hr", 32'(hr_o), 10);
    check("bad_set.min", 32'(min_o), 0);
    check("bad_set.buzzer", 32'(buzzer_o), 1);
    do_wr(3, 10, 0, 1'b0);
    check("disable.buzzer", 32'(buzzer_o), 0);
    check("disable.snoozed", 32'(snoozed_o), 0);

    // Asynchronous reset mid-ring, then the alarm table must be empty
    do_wr(2, 11, 0, 1'b1);
    do_set(10, 59);
    wait_ticks(60);
    check("ring1100.buzzer", 32'(buzzer_o), 1);
    check("ring1100.idx", 32'(ring_idx_o), 2);
    #2 rst = 1'b1;
    #1;
    check("arst.buzzer", 32'(buzzer_o), 0);
    check("arst.snoozed", 32'(snoozed_o), 0);
    check("arst.ring_idx", 32'(ring_idx_o), 0);
    check("arst.sec_tick", 32'(sec_tick_o), 0);
    check_time("arst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    do_set(10, 59);
    wait_ticks(60);
    check_time("post_rst1100", 11, 0, 0);
    check("post_rst.buzzer", 32'(buzzer_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_multi_alarm.md
Name: rtc_multi_alarm

Overview:
Single-clock-domain real-time clock (hh:mm:ss, 24 h) with N independently programmable alarm channels, snooze, dismiss and auto-timeout.
- Replaces the derived-clock style with a one-cycle seconds tick enable, so all logic runs on clk.
- Alarm matching is edge-triggered: one ring event per match, not a level held for the whole minute.
- Sits between board clock/buttons and the buzzer/display drivers.

Parameters:
- CLK_HZ, 100_000_000, clk frequency; sec_tick period is CLK_HZ cycles.
- N_ALARMS, 4, number of alarm channels (1..16).
- SNOOZE_MIN, 5, snooze duration in minutes (1..59).
- RING_MIN, 1, auto-dismiss timeout in minutes (1..59).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- set_time  in  1  one-cycle strobe: load set_hr/set_min, sec=0
- set_hr  in  5  hour to load, 0..23
- set_min  in  6  minute to load, 0..59
- alarm_wr  in  1  one-cycle strobe: write alarm entry alarm_idx
- alarm_idx  in  $clog2(N_ALARMS) (min 1)  channel to write
- alarm_hr  in  5  alarm hour
- alarm_min  in  6  alarm minute
- alarm_en  in  1  enable bit written with the entry
- snooze  in  1  one-cycle strobe (pre-synchronised, debounced)
- dismiss  in  1  one-cycle strobe (pre-synchronised, debounced)
- hr  out  5  current hour
- min  out  6  current minute
- sec  out  6  current second
- sec_tick  out  1  one-cycle pulse per second
- buzzer  out  1  high while RINGING
- ring_idx  out  $clog2(N_ALARMS)  channel that caused the current ring/snooze
- snoozed  out  1  high while SNOOZED

Behaviour:
- Reset: hr=min=sec=0, prescaler=0, sec_tick=0, all alarm entries hr=0 min=0 en=0, state IDLE, buzzer=0, snoozed=0, ring_idx=0, timers=0. Reset mid-ring returns to IDLE immediately.
- Prescaler:
  - counts 0..CLK_HZ-1.
  - sec_tick is registered and high for the cycle after count==CLK_HZ-1, so the first tick occurs CLK_HZ cycles after reset release.
- Time update on sec_tick:
  - sec 59→0 carries to min; min 59→0 carries to hr; hr 23→0.
  - 23:59:59 → 00:00:00.
- set_time:
  - Has priority over a coincident tick. Loads hr/min, sets sec=0, clears the prescaler.
  - Ignored entirely if set_hr>23 or set_min>59.
  - Never triggers an alarm.
- alarm_wr: writes {hr,min,en} to entry alarm_idx. Ignored if alarm_hr>23, alarm_min>59 or alarm_idx>=N_ALARMS.
- Match:
  - Evaluated only on a sec_tick where sec==59 (minute rollover), against the next hr:min.
  - A channel matches if en=1 and its hr:min equals the next time.
  - If several match, the lowest index wins.
  - In IDLE, the FSM enters RINGING on the same clk edge that the time becomes hh:mm:00.
- FSM states IDLE, RINGING, SNOOZED:
  - IDLE → RINGING: match; ring_idx latched, ring timer=RING_MIN*60.
  - RINGING, dismiss → IDLE.
  - RINGING, snooze → SNOOZED; snooze timer=SNOOZE_MIN*60.
  - RINGING: ring timer decrements on each sec_tick; reaching 0 → IDLE (auto-dismiss).
  - SNOOZED: snooze timer decrements on each sec_tick; reaching 0 → RINGING with the same ring_idx and ring timer reloaded.
  - SNOOZED, dismiss → IDLE.
  - snooze and dismiss in the same cycle: dismiss wins. snooze in IDLE/SNOOZED and dismiss in IDLE are ignored.
  - A match while RINGING/SNOOZED is dropped and not queued.
  - alarm_wr clearing en of ring_idx while RINGING/SNOOZED → IDLE on the next edge.
  - set_time does not alter FSM state or timers.
- Outputs: buzzer = (state==RINGING); snoozed = (state==SNOOZED). Both registered/state-decoded, no combinational paths from inputs.
- Widths: timers are 12 bit (max 3540 s). Time counters never exceed their legal range under any input.

Decomposition:
- Package rtc_pkg holds:
  - constants HR_MAX=23, MIN_MAX=59, SEC_MAX=59
  - state enum {IDLE, RINGING, SNOOZED}
  - alarm entry struct {hr[4:0], min[5:0], en}
  - function valid_hm(hr,min)
- One natural sub-module: rtc_tick_gen (parameter CLK_HZ; ports clk, rst, clr, tick).
- Alarm table, matcher and FSM stay in the top module.

Test Plan:
- Simulation uses CLK_HZ=4, N_ALARMS=4, SNOOZE_MIN=1, RING_MIN=2.
- Reset release, run 4 cycles → first sec_tick after 4 cycles; set_time 23:59, run 60 ticks → 00:00:00, no buzzer.
- Alarm ch2=07:30 en, set_time 07:29 → buzzer rises on the edge time shows 07:30:00, ring_idx=2; dismiss at 07:30:10 → buzzer=0 next cycle, no re-trigger during the rest of 07:30.
- Ch1 and ch3 both 08:00 en → ring_idx=1; no dismiss → buzzer drops exactly 120 ticks later (08:02:00).
- Ringing, pulse snooze → buzzer=0, snoozed=1; after 60 ticks → buzzer=1, same ring_idx; snooze+dismiss same cycle → IDLE.
- Writes: alarm_wr with hr=24 or min=60, and set_time 25:00 → state unchanged; disable the ringing channel via alarm_wr → IDLE. Assert rst mid-RINGING → all outputs at reset values asynchronously.
